dbg_cmd_bridge: RTL and testbench

Byte-stream command front end for the debug register/CSR access port. It parses read and write commands from a host byte stream (UART/JTAG transport side) and issues single-cycle access requests to the debug access port. It waits for that port's ready pulse and returns status and read data as a response byte stream. It sits directly upstream of the debug access port and drives its enable/addr/read/write/write-data inputs.

---
 rtl/dbg_cmd_bridge.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_dbg_cmd_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_bridge.sv
// Byte-stream command front end for the debug access port: parses read/write
// commands, issues one access strobe, returns ACK/NAK plus read data.
// Define DBG_CMD_CHECKSUM_EN to add XOR checksum bytes to commands and responses.
module dbg_cmd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_enable,
  output logic [11:0] dbg_addr,
  output logic        dbg_read,
  output logic        dbg_write,
  output logic [31:0] dbg_write_data,
  input  logic [31:0] dbg_read_data,
  input  logic        dbg_ready,
  output logic        busy,
  output logic [7:0]  nak_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
`ifdef DBG_CMD_CHECKSUM_EN
    S_CHK,
`endif
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    OP_RD    = 8'h52;
  localparam logic [7:0]    OP_WR    = 8'h57;

  state_e        state_q, state_d;
  logic          op_wr_q, op_wr_d;
  logic [15:0]   addr_buf_q, addr_buf_d;
  logic [31:0]   data_buf_q, data_buf_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [39:0]   resp_sh_q, resp_sh_d;
  logic [2:0]    resp_rem_q, resp_rem_d;
  logic          resp_first_q, resp_first_d;
  logic          resp_nak_q, resp_nak_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          dbg_enable_q, dbg_enable_d;
  logic          dbg_read_q, dbg_read_d;
  logic          dbg_write_q, dbg_write_d;
  logic [11:0]   dbg_addr_q, dbg_addr_d;
  logic [31:0]   dbg_wdata_q, dbg_wdata_d;
  logic [7:0]    nak_count_q, nak_count_d;
`ifdef DBG_CMD_CHECKSUM_EN
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    resp_chk;
`endif

  logic       rx_fire, tx_fire, cmd_done, chk_bad, start_resp, resp_nak, resp_rd;
  logic [7:0] resp_status;

  always_comb begin
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA: rx_ready = !reset;
`ifdef DBG_CMD_CHECKSUM_EN
      S_CHK:                                rx_ready = !reset;
`endif
      default:                              rx_ready = 1'b0;
    endcase
  end

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid_q && tx_ready;

  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    addr_buf_d   = addr_buf_q;
    data_buf_d   = data_buf_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_d        = tmo_q;
    resp_sh_d    = resp_sh_q;
    resp_rem_d   = resp_rem_q;
    resp_first_d = resp_first_q;
    resp_nak_d   = resp_nak_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    dbg_enable_d = 1'b0;
    dbg_read_d   = 1'b0;
    dbg_write_d  = 1'b0;
    dbg_addr_d   = dbg_addr_q;
    dbg_wdata_d  = dbg_wdata_q;
    nak_count_d  = nak_count_q;
`ifdef DBG_CMD_CHECKSUM_EN
    chk_d        = chk_q;
    resp_chk     = '0;
`endif
    cmd_done     = 1'b0;
    chk_bad      = 1'b0;
    start_resp   = 1'b0;
    resp_nak     = 1'b0;
    resp_rd      = 1'b0;
    resp_status  = ACK_BYTE;

    case (state_q)
      S_IDLE: if (rx_fire) begin
`ifdef DBG_CMD_CHECKSUM_EN
        chk_d = rx_data;
`endif
        if (rx_data == OP_RD || rx_data == OP_WR) begin
          op_wr_d = (rx_data == OP_WR);
          state_d = S_ADDR_HI;
        end else begin
          start_resp = 1'b1;
          resp_nak   = 1'b1;
        end
      end
      S_ADDR_HI: if (rx_fire) begin
`ifdef DBG_CMD_CHECKSUM_EN
        chk_d = chk_q ^ rx_data;
`endif
        addr_buf_d[15:8] = rx_data;
        state_d          = S_ADDR_LO;
      end
      S_ADDR_LO: if (rx_fire) begin
`ifdef DBG_CMD_CHECKSUM_EN
        chk_d = chk_q ^ rx_data;
`endif
        addr_buf_d[7:0] = rx_data;
        byte_cnt_d      = '0;
        if (op_wr_q) state_d = S_DATA;
`ifdef DBG_CMD_CHECKSUM_EN
        else         state_d = S_CHK;
`else
        else         cmd_done = 1'b1;
`endif
      end
      S_DATA: if (rx_fire) begin
`ifdef DBG_CMD_CHECKSUM_EN
        chk_d = chk_q ^ rx_data;
`endif
        data_buf_d = {data_buf_q[23:0], rx_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
`ifdef DBG_CMD_CHECKSUM_EN
          state_d = S_CHK;
`else
          cmd_done = 1'b1;
`endif
        end
      end
`ifdef DBG_CMD_CHECKSUM_EN
      S_CHK: if (rx_fire) begin
        cmd_done = 1'b1;
        chk_bad  = (rx_data != chk_q);
      end
`endif
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dbg_ready) begin
          start_resp = 1'b1;
          resp_rd    = !op_wr_q;
        end else if (tmo_q == TMO_LAST) begin
          start_resp = 1'b1;
          resp_nak   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: if (tx_fire) begin
        resp_first_d = 1'b0;
        if (resp_first_q && resp_nak_q && nak_count_q != 8'hFF)
          nak_count_d = nak_count_q + 8'd1;
        if (resp_rem_q == 3'd0) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end else begin
          tx_data_d  = resp_sh_q[39:32];
          resp_sh_d  = {resp_sh_q[31:0], 8'h00};
          resp_rem_d = resp_rem_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address/checksum are judged with the final byte folded in, so a rejected
    // command never reaches ISSUE and the port sees no strobe.
    if (cmd_done) begin
      if (addr_buf_d[15:12] != 4'h0 || chk_bad) begin
        start_resp = 1'b1;
        resp_nak   = 1'b1;
      end else begin
        state_d      = S_ISSUE;
        dbg_enable_d = 1'b1;
        dbg_read_d   = !op_wr_q;
        dbg_write_d  = op_wr_q;
        dbg_addr_d   = addr_buf_d[11:0];
        dbg_wdata_d  = data_buf_d;
      end
    end

    if (start_resp) begin
      resp_status  = resp_nak ? NAK_BYTE : ACK_BYTE;
      state_d      = S_RESP;
      tx_valid_d   = 1'b1;
      tx_data_d    = resp_status;
      resp_first_d = 1'b1;
      resp_nak_d   = resp_nak;
`ifdef DBG_CMD_CHECKSUM_EN
      if (resp_rd) begin
        resp_chk   = resp_status ^ dbg_read_data[31:24] ^ dbg_read_data[23:16]
                   ^ dbg_read_data[15:8] ^ dbg_read_data[7:0];
        resp_sh_d  = {dbg_read_data, resp_chk};
        resp_rem_d = 3'd5;
      end else begin
        resp_sh_d  = {resp_status, 32'h0};
        resp_rem_d = 3'd1;
      end
`else
      resp_sh_d  = {dbg_read_data, 8'h00};
      resp_rem_d = resp_rd ? 3'd4 : 3'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_wr_q      <= 1'b0;
      addr_buf_q   <= '0;
      data_buf_q   <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      resp_sh_q    <= '0;
      resp_rem_q   <= '0;
      resp_first_q <= 1'b0;
      resp_nak_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      dbg_enable_q <= 1'b0;
      dbg_read_q   <= 1'b0;
      dbg_write_q  <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
      nak_count_q  <= '0;
`ifdef DBG_CMD_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_wr_q      <= op_wr_d;
      addr_buf_q   <= addr_buf_d;
      data_buf_q   <= data_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      resp_sh_q    <= resp_sh_d;
      resp_rem_q   <= resp_rem_d;
      resp_first_q <= resp_first_d;
      resp_nak_q   <= resp_nak_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      dbg_enable_q <= dbg_enable_d;
      dbg_read_q   <= dbg_read_d;
      dbg_write_q  <= dbg_write_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_wdata_q  <= dbg_wdata_d;
      nak_count_q  <= nak_count_d;
`ifdef DBG_CMD_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign dbg_enable     = dbg_enable_q;
  assign dbg_read       = dbg_read_q;
  assign dbg_write      = dbg_write_q;
  assign dbg_addr       = dbg_addr_q;
  assign dbg_write_data = dbg_wdata_q;
  assign nak_count      = nak_count_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Randomized self-checking bench for dbg_cmd_bridge: a transaction-level model
// predicts response bytes, access port activity and the NAK counter.
module tb_dbg_cmd_bridge;
  localparam int         TMO = 12;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        dbg_enable;
  logic [11:0] dbg_addr;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_write_data;
  logic [31:0] dbg_read_data = '0;
  logic        dbg_ready = 1'b0;
  logic        busy;
  logic [7:0]  nak_count;

  always #5 clk = ~clk;

  dbg_cmd_bridge #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_enable(dbg_enable), .dbg_addr(dbg_addr), .dbg_read(dbg_read),
    .dbg_write(dbg_write), .dbg_write_data(dbg_write_data),
    .dbg_read_data(dbg_read_data), .dbg_ready(dbg_ready),
    .busy(busy), .nak_count(nak_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Debug access port responder: records strobes, answers after ready_delay WAIT cycles.
  int          ready_delay = 0;
  logic [31:0] rdata_cfg = '0;
  bit          pend = 1'b0;
  int          cd = 0;
  int          acc_cnt = 0;
  logic [11:0] acc_addr = '0;
  logic        acc_rd = 1'b0;
  logic        acc_wr = 1'b0;
  logic [31:0] acc_wdata = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      dbg_ready = 1'b0;
      pend      = 1'b0;
    end else begin
      dbg_ready     = 1'b0;
      dbg_read_data = $urandom;
      if (pend) begin
        if (cd == 0) begin
          dbg_ready     = 1'b1;
          dbg_read_data = rdata_cfg;
          pend          = 1'b0;
        end else cd--;
      end
      if (dbg_enable) begin
        acc_cnt++;
        acc_addr  = dbg_addr;
        acc_rd    = dbg_read;
        acc_wr    = dbg_write;
        acc_wdata = dbg_write_data;
        pend      = 1'b1;
        cd        = ready_delay;
      end
    end
  end

  // Transport sink with optional random or fixed back-pressure.
  logic [7:0] got_q[$];
  int         bp_hold_at = -1;
  int         held = 0;
  bit         bp_rand = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] stall_data = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall    = 1'b0;
      tx_ready = 1'b0;
    end else begin
      if (stall) check_eq("tx_hold", {tx_valid, tx_data}, {1'b1, stall_data});
      if (tx_valid) check_eq("rx_ready_in_resp", rx_ready, 0);
      if (tx_valid && bp_hold_at >= 0 && got_q.size() == bp_hold_at && held < 10) begin
        tx_ready = 1'b0;
        held++;
      end else if (bp_rand) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      stall      = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  logic [11:0] m_addr = '0;
  int          m_nak = 0;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_accept", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // kind: 0 read, 1 write, 2 bad opcode
  task automatic run_cmd(input int kind, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [7:0] badop, input int delay,
                         input bit lat_chk, input bit bad_chk);
    logic [7:0] cmd[$];
    logic [7:0] exp[$];
    logic [7:0] x;
    bit         nak, acc;
    int         base, a0, n;
    ready_delay = delay;
    rdata_cfg   = rdata;
    if (kind == 2) cmd.push_back(badop);
    else begin
      cmd.push_back(kind == 0 ? 8'h52 : 8'h57);
      cmd.push_back(addr[15:8]);
      cmd.push_back(addr[7:0]);
      if (kind == 1) for (int i = 3; i >= 0; i--) cmd.push_back(wdata[i*8 +: 8]);
`ifdef DBG_CMD_CHECKSUM_EN
      x = '0;
      foreach (cmd[i]) x ^= cmd[i];
      if (bad_chk) x = ~x;
      cmd.push_back(x);
`endif
    end
    acc = (kind != 2) && (addr[15:12] == 4'h0) && !bad_chk;
    nak = !acc || (delay >= TMO);
    exp.push_back(nak ? NAK : ACK);
    if (!nak && kind == 0) for (int i = 3; i >= 0; i--) exp.push_back(rdata[i*8 +: 8]);
`ifdef DBG_CMD_CHECKSUM_EN
    x = '0;
    foreach (exp[i]) x ^= exp[i];
    exp.push_back(x);
`endif
    base = got_q.size();
    a0   = acc_cnt;
    foreach (cmd[i]) begin
      repeat ($urandom_range(0, lat_chk ? 0 : 2)) @(negedge clk);
      send_byte(cmd[i]);
    end
    if (lat_chk) begin
      n = 0;
      while (!tx_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      check_eq("read_latency", n, 2);
    end
    n = 0;
    while ((got_q.size() < base + exp.size() || busy || pend) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_done", n < 400, 1);
    repeat (3) @(negedge clk);
    check_eq("resp_len", got_q.size() - base, exp.size());
    foreach (exp[i])
      if (base + i < got_q.size()) check_eq($sformatf("resp_byte%0d", i), got_q[base+i], exp[i]);
    check_eq("access_count", acc_cnt - a0, acc);
    if (acc) begin
      m_addr = addr[11:0];
      check_eq("acc_addr", acc_addr, addr[11:0]);
      check_eq("acc_rw", {acc_rd, acc_wr}, (kind == 0) ? 2'b10 : 2'b01);
      if (kind == 1) check_eq("acc_wdata", acc_wdata, wdata);
    end
    check_eq("dbg_addr_hold", dbg_addr, m_addr);
    if (nak && m_nak < 255) m_nak++;
    check_eq("nak_count", nak_count, m_nak);
    check_eq("busy_idle", busy, 0);
  endtask

  int          r, d, k;
  logic [15:0] a;
  logic [7:0]  bo;
  bit          bc;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {rx_ready, tx_valid, dbg_enable, dbg_read, dbg_write, busy}, '0);
    check_eq("rst_data", {tx_data, dbg_addr, dbg_write_data, nak_count}, '0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_rx_ready", rx_ready, 1);

    run_cmd(0, 16'h0005, 32'h0, 32'hDEADBEEF, 8'h0, 0, 1, 0);
    run_cmd(1, 16'h0801, 32'h12345678, 32'h0, 8'h0, 2, 0, 0);
    run_cmd(2, 16'h0, 32'h0, 32'h0, 8'h41, 0, 0, 0);
    run_cmd(0, 16'h0010, 32'h0, 32'hCAFEF00D, 8'h0, 1, 0, 0);
    run_cmd(0, 16'h1005, 32'h0, 32'h11111111, 8'h0, 0, 0, 0);
    run_cmd(1, 16'hF123, 32'hA5A5A5A5, 32'h0, 8'h0, 0, 0, 0);
    run_cmd(0, 16'h0123, 32'h0, 32'h0BADF00D, 8'h0, TMO, 0, 0);
    run_cmd(1, 16'h0456, 32'h01020304, 32'h0, 8'h0, TMO + 3, 0, 0);
    run_cmd(0, 16'h0789, 32'h0, 32'h89ABCDEF, 8'h0, TMO - 1, 0, 0);
`ifdef DBG_CMD_CHECKSUM_EN
    run_cmd(1, 16'h0042, 32'h55AA55AA, 32'h0, 8'h0, 0, 0, 1);
`endif

    bp_hold_at = got_q.size() + 2;
    run_cmd(0, 16'h0ABC, 32'h0, 32'h13579BDF, 8'h0, 0, 0, 0);
    check_eq("bp_held_cycles", held, 10);
    bp_hold_at = -1;

    ready_delay = 10000;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h09);
`ifdef DBG_CMD_CHECKSUM_EN
    send_byte(8'h52 ^ 8'h09);
`endif
    repeat (3) @(negedge clk);
    check_eq("wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_wait_ctrl", {rx_ready, tx_valid, dbg_enable, dbg_read, dbg_write, busy}, '0);
    check_eq("rst_wait_data", {tx_data, dbg_addr, dbg_write_data, nak_count}, '0);
    m_addr = '0;
    m_nak  = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_cmd(0, 16'h0003, 32'h0, 32'h76543210, 8'h0, 0, 0, 0);

    bp_rand = 1'b1;
    for (int t = 0; t < 80; t++) begin
      r  = $urandom_range(0, 9);
      a  = {4'h0, 12'($urandom)};
      k  = (r < 4) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : 3;
      if (k == 3) begin
        a[15:12] = 4'($urandom_range(1, 15));
        k        = $urandom_range(0, 1);
      end
      bo = 8'($urandom);
      if (bo == 8'h52 || bo == 8'h57) bo = 8'h00;
      d  = $urandom_range(0, 9);
      d  = (d < 7) ? int'($urandom_range(0, 4)) : (d == 7) ? TMO - 1 : (d == 8) ? TMO : TMO + 2;
      bc = 1'b0;
`ifdef DBG_CMD_CHECKSUM_EN
      bc = ($urandom_range(0, 7) == 0);
`endif
      run_cmd(k, a, $urandom, $urandom, bo, d, 0, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
